pixel_on_line_check: RTL and testbench

Pipelined per-pixel test that decides whether pixel (x,y) lies on a thick line segment. The segment starts at (x0,y0), follows the unit direction (xn,yn) and has length mag. All coordinates are signed Q16.16 fixed point. Sits in the render path of the fluid-simulation display, where it is evaluated once per pixel per vector to draw velocity arrows.

---
 rtl/pixel_on_line_check.sv | 117 +++++++++++
 tb/tb_pixel_on_line_check.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pixel_on_line_check.sv
// Three-stage pipelined test of whether pixel (x,y) lies on a thick segment
// starting at (x0,y0), running along (xn,yn) for length mag; all signed Q16.16.
module pixel_on_line_check #(
    parameter int          WIDTH          = 32,
    parameter int          FRAC           = 16,
    parameter int unsigned LINE_WIDTH_SQR = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] xn,
    input  logic [WIDTH-1:0] yn,
    input  logic [WIDTH-1:0] mag,
    output logic             out_valid,
    output logic             on_line
);

    localparam int DW = WIDTH + 1;
    localparam int PW = 2 * WIDTH + 1;
    localparam int SW = PW + 1;
    localparam int QW = 2 * SW;
    localparam logic [QW-1:0] BAND_SQR = QW'(LINE_WIDTH_SQR) << (2 * FRAC);

    // Stage 1 registers
    logic                    valid1_q;
    logic signed [DW-1:0]    dx_q, dy_q;
    logic signed [DW-1:0]    dx_d, dy_d;
    logic signed [WIDTH-1:0] xn_q, yn_q, mag1_q;

    // Stage 2 registers
    logic                    valid2_q;
    logic signed [SW-1:0]    t_q, p_q;
    logic signed [SW-1:0]    t_d, p_d;
    logic signed [WIDTH-1:0] mag2_q;

    // Stage 3 registers
    logic out_valid_q, on_line_q, on_line_d;

    // Stage 1: differences one bit wider than the inputs so they cannot wrap
    logic signed [DW-1:0] x_e, y_e, x0_e, y0_e;
    always_comb begin
        x_e  = {x[WIDTH-1], x};
        y_e  = {y[WIDTH-1], y};
        x0_e = {x0[WIDTH-1], x0};
        y0_e = {y0[WIDTH-1], y0};
        dx_d = x_e - x0_e;
        dy_d = y_e - y0_e;
    end

    // Stage 2: operands widened explicitly to product width before multiplying
    logic signed [PW-1:0] dx_w, dy_w, xn_w, yn_w;
    logic signed [PW-1:0] dxxn, dyyn, dxyn, dyxn;
    logic signed [SW-1:0] t_sum, p_sum;
    always_comb begin
        dx_w  = {{(PW-DW){dx_q[DW-1]}}, dx_q};
        dy_w  = {{(PW-DW){dy_q[DW-1]}}, dy_q};
        xn_w  = {{(PW-WIDTH){xn_q[WIDTH-1]}}, xn_q};
        yn_w  = {{(PW-WIDTH){yn_q[WIDTH-1]}}, yn_q};
        dxxn  = dx_w * xn_w;
        dyyn  = dy_w * yn_w;
        dxyn  = dx_w * yn_w;
        dyxn  = dy_w * xn_w;
        t_sum = {dxxn[PW-1], dxxn} + {dyyn[PW-1], dyyn};
        p_sum = {dxyn[PW-1], dxyn} - {dyxn[PW-1], dyxn};
        t_d   = t_sum >>> FRAC;
        p_d   = p_sum >>> FRAC;
    end

    // Stage 3: extent and band tests, all inclusive
    logic signed [QW-1:0] p_w, psq;
    logic signed [SW-1:0] mag_w;
    always_comb begin
        p_w       = {{(QW-SW){p_q[SW-1]}}, p_q};
        psq       = p_w * p_w;
        mag_w     = {{(SW-WIDTH){mag2_q[WIDTH-1]}}, mag2_q};
        on_line_d = valid2_q && !t_q[SW-1] && (t_q <= mag_w)
                    && ($unsigned(psq) <= BAND_SQR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_q    <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            xn_q        <= '0;
            yn_q        <= '0;
            mag1_q      <= '0;
            valid2_q    <= 1'b0;
            t_q         <= '0;
            p_q         <= '0;
            mag2_q      <= '0;
            out_valid_q <= 1'b0;
            on_line_q   <= 1'b0;
        end else begin
            valid1_q    <= in_valid;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            xn_q        <= xn;
            yn_q        <= yn;
            mag1_q      <= mag;
            valid2_q    <= valid1_q;
            t_q         <= t_d;
            p_q         <= p_d;
            mag2_q      <= mag1_q;
            out_valid_q <= valid2_q;
            on_line_q   <= on_line_d;
        end
    end

    assign out_valid = out_valid_q;
    assign on_line   = out_valid_q & on_line_q;

endmodule

// File: tb/tb_pixel_on_line_check.sv
// Directed, table-driven bench for pixel_on_line_check: hand-computed vectors
// streamed back-to-back, with gaps, and across a mid-stream reset.
module tb_pixel_on_line_check;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] x, y, x0, y0, xn, yn, mag;
    logic        out_valid, on_line;

    pixel_on_line_check #(
        .WIDTH(32),
        .FRAC(16),
        .LINE_WIDTH_SQR(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .x(x),
        .y(y),
        .x0(x0),
        .y0(y0),
        .xn(xn),
        .yn(yn),
        .mag(mag),
        .out_valid(out_valid),
        .on_line(on_line)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x, y, x0, y0, xn, yn, mag;
        logic        exp;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl[NV];
    vec_t idle;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic [2:0] pv = '0;
    logic [2:0] po = '0;

    function automatic logic [31:0] q(input int n);
        return 32'(n) << 16;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at a negedge; drives one input cycle and checks against a
    // 3-deep expected pipeline.
    task automatic step(input logic v, input vec_t t);
        in_valid = v;
        x = t.x;  y = t.y;  x0 = t.x0;  y0 = t.y0;
        xn = t.xn; yn = t.yn; mag = t.mag;
        @(posedge clk);
        pv = {pv[1:0], v};
        po = {po[1:0], t.exp};
        @(negedge clk);
        chk("out_valid", out_valid, pv[2]);
        chk("on_line", on_line, pv[2] & po[2]);
    endtask

    task automatic flush();
        for (int k = 0; k < 3; k++) step(1'b0, idle);
    endtask

    initial begin
        idle = '{'0, '0, '0, '0, '0, '0, '0, 1'b0};
        //          x              y              x0            y0            xn            yn            mag           exp
        tbl[0]  = '{q(5),          q(10),         q(0),         q(0),         32'h0000B505, 32'h0000B505, q(20),        1'b1};
        tbl[1]  = '{q(10),         q(10),         q(0),         q(0),         32'h0000B505, 32'h0000B505, q(30),        1'b1};
        tbl[2]  = '{q(17),         q(17),         q(20),        q(15),        q(0),         q(1),         q(10),        1'b1};
        tbl[3]  = '{q(17),         q(17),         q(20),        q(20),        32'hFFFF3F38, 32'h0000A86F, 32'h000A6126, 1'b1};
        tbl[4]  = '{q(25),         q(25),         q(0),         q(0),         32'h0000B505, 32'h0000B505, q(20),        1'b0};
        tbl[5]  = '{q(-1),         q(-1),         q(0),         q(0),         32'h0000B505, 32'h0000B505, q(20),        1'b0};
        tbl[6]  = '{q(0),          q(20),         q(0),         q(0),         32'h0000B505, 32'h0000B505, q(30),        1'b0};
        tbl[7]  = '{q(5),          q(10),         q(0),         q(0),         q(1),         q(0),         q(20),        1'b1};
        tbl[8]  = '{q(5),          32'h000A0001,  q(0),         q(0),         q(1),         q(0),         q(20),        1'b0};
        tbl[9]  = '{q(0),          q(0),          q(0),         q(0),         q(1),         q(0),         q(-1),        1'b0};
        tbl[10] = '{q(0),          q(0),          q(0),         q(0),         q(1),         q(0),         q(0),         1'b1};
        tbl[11] = '{q(0),          q(1),          q(0),         q(0),         q(1),         q(0),         q(0),         1'b1};
        // dx = 65535.0 only fits with the widened difference; t ~ 1.0 with a tiny xn
        tbl[12] = '{32'h7FFF0000,  q(0),          32'h80000000, q(0),         32'h00000001, q(0),         q(2),         1'b1};
        // dy = 65535.0 puts the point far off the band; a wrapped dy would land inside it
        tbl[13] = '{q(0),          32'h7FFF0000,  q(0),         32'h80000000, q(1),         q(0),         q(20),        1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        x = '0; y = '0; x0 = '0; y0 = '0; xn = '0; yn = '0; mag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset on_line", on_line, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) step(1'b1, tbl[i]);
        flush();

        for (int i = 0; i < NV; i++) begin
            step(1'b1, tbl[i]);
            if (i % 3 == 0) step(1'b0, idle);
        end
        flush();

        for (int i = 0; i < 5; i++) step(1'b1, tbl[i]);
        rst = 1'b1;
        #1;
        chk("async reset out_valid", out_valid, 1'b0);
        chk("async reset on_line", on_line, 1'b0);
        pv = '0;
        po = '0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("held reset out_valid", out_valid, 1'b0);
        rst = 1'b0;
        flush();
        for (int i = 5; i < NV; i++) step(1'b1, tbl[i]);
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
